fifo_inst_driver: RTL and testbench

- Initiator for the FIFO instruction port: converts a write-request stream and a read-request stream into the packed instruction word {WE, RE, DI}.
- That word is consumed by the single-port-RAM FIFO, which returns DO qualified by read_valid.
- Keeps a shadow occupancy count so the FIFO is never overflowed or underflowed, and arbitrates the single RAM port one operation per cycle.
- Re-times returned data onto a clean response interface, and supports a flush that drains the FIFO.

---
 rtl/fifo_drv_pkg.sv | 33 +++
 rtl/fifo_drv_tagq.sv | 72 +++++++
 rtl/fifo_inst_driver.sv | 172 +++++++++++++++++
 tb/tb_fifo_inst_driver.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drv_pkg
// Description : Shared defaults, instruction-word layout and state types for
//               the FIFO instruction-port driver.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_drv_pkg;

    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH      = 3;
    localparam int DEF_MAX_OUTSTANDING = 4;

    // Instruction word is {WE, RE, DI}
    localparam int INST_W  = DEF_DATA_WIDTH + 2;
    localparam int INST_WE = DEF_DATA_WIDTH + 1;
    localparam int INST_RE = DEF_DATA_WIDTH;

    // Drain sequencing: normal issue, flush drain, wait for in-flight reads
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } drv_state_t;

    // Side that won the most recent accepted transfer
    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

endpackage : fifo_drv_pkg
`default_nettype wire

// File: rtl/fifo_drv_tagq.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drv_tagq
// Description : Small shift queue of 1-bit drain tags, one per outstanding
//               read. Push on read issue, pop on returned read data. The head
//               tag tells whether the returning data is forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drv_tagq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic             i_push_tag,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic             o_head_tag
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [DEPTH-1:0] tags_q, tags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_slot;

    // Never pop an empty queue; a push into a full queue is only legal with a pop
    assign w_pop  = i_pop && (cnt_q != '0);
    assign w_push = i_push && ((cnt_q != C_DEPTH) || w_pop);
    assign w_slot = w_pop ? (cnt_q - C_ONE) : cnt_q;

    // Shift toward the head on pop, then drop a new tag into the first free slot
    always_comb begin
        tags_d = tags_q;
        cnt_d  = cnt_q;
        if (w_pop) begin
            tags_d = tags_q >> 1;
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == w_slot) begin
                    tags_d[i] = i_push_tag;
                end
            end
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + C_ONE;
            2'b01:   cnt_d = cnt_q - C_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue storage and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tags_q <= '0;
            cnt_q  <= '0;
        end else begin
            tags_q <= tags_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_count    = cnt_q;
    assign o_head_tag = tags_q[0];

endmodule : fifo_drv_tagq
`default_nettype wire

// File: rtl/fifo_inst_driver.sv
`default_nettype none
// ============================================================================
// Module      : fifo_inst_driver
// Description : Initiator for a single-port-RAM FIFO instruction port. Merges
//               write and read request streams into {WE, RE, DI}, keeps a
//               shadow occupancy so the FIFO never over/underflows, re-times
//               returned data and supports a flush that drains the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_inst_driver
    import fifo_drv_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH+1:0] inst,
    input  logic [DATA_WIDTH-1:0] DO,
    input  logic                  read_valid,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic                  err
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(1 << ADDR_WIDTH);
    localparam logic [CNT_W-1:0] C_CNT1   = CNT_W'(1);
    localparam logic [OS_W-1:0]  C_MAX_OS = OS_W'(MAX_OUTSTANDING);

    drv_state_t            state_q, state_d;
    grant_t                last_grant_q, last_grant_d;
    logic [DATA_WIDTH+1:0] inst_q, inst_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_data_valid_q, rd_data_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    logic [OS_W-1:0]       w_outstanding;
    logic                  w_head_tag;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_os_ok;
    logic                  w_w_elig;
    logic                  w_r_elig;
    logic                  w_grant_w;
    logic                  w_grant_r;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_drain_rd;
    logic                  w_rd_issue;
    logic                  w_rv_ok;
    logic                  w_rv_err;

    assign w_full  = (count_q == C_DEPTH);
    assign w_empty = (count_q == '0);
    assign w_os_ok = (w_outstanding < C_MAX_OS);

    // Round-robin between the two request streams; the loser of the last
    // accepted transfer wins a tie, a lone eligible requester always wins
    assign w_w_elig  = wr_valid && !w_full;
    assign w_r_elig  = rd_req_valid && !w_empty && w_os_ok;
    assign w_grant_w = w_w_elig && (!w_r_elig || (last_grant_q == GRANT_READ));
    assign w_grant_r = w_r_elig && (!w_w_elig || (last_grant_q == GRANT_WRITE));

    assign wr_ready     = (state_q == ISSUE) && !w_full && w_grant_w;
    assign rd_req_ready = (state_q == ISSUE) && !w_empty && w_os_ok && w_grant_r;

    assign w_wr_acc   = wr_valid && wr_ready;
    assign w_rd_acc   = rd_req_valid && rd_req_ready;
    assign w_drain_rd = (state_q == DRAIN) && !w_empty && w_os_ok;
    assign w_rd_issue = w_rd_acc || w_drain_rd;

    // Returned data with nothing in flight is a protocol error, not a response
    assign w_rv_ok  = read_valid && (w_outstanding != '0);
    assign w_rv_err = read_valid && (w_outstanding == '0);

    fifo_drv_tagq #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (OS_W)
    ) u_tagq (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_rd_issue),
        .i_push_tag (w_drain_rd),
        .i_pop      (w_rv_ok),
        .o_count    (w_outstanding),
        .o_head_tag (w_head_tag)
    );

    // Next instruction, occupancy, response and drain-sequencing state
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        inst_d          = {2'b00, inst_q[DATA_WIDTH-1:0]};
        count_d         = count_q;
        rd_data_valid_d = 1'b0;
        rd_data_d       = rd_data_q;
        err_d           = err_q | w_rv_err;

        // Write and read issue are mutually exclusive by construction
        if (w_wr_acc) begin
            inst_d       = {2'b10, wr_data};
            count_d      = count_q + C_CNT1;
            last_grant_d = GRANT_WRITE;
        end else if (w_rd_issue) begin
            inst_d  = {2'b01, inst_q[DATA_WIDTH-1:0]};
            count_d = count_q - C_CNT1;
            if (w_rd_acc) begin
                last_grant_d = GRANT_READ;
            end
        end

        // Drain-tagged responses are swallowed
        if (w_rv_ok && !w_head_tag) begin
            rd_data_valid_d = 1'b1;
            rd_data_d       = DO;
        end

        case (state_q)
            ISSUE:   if (flush) state_d = DRAIN;
            DRAIN:   if (w_empty) state_d = WAIT;
            WAIT:    if (w_outstanding == '0) state_d = ISSUE;
            default: state_d = ISSUE;
        endcase
    end

    // All driver state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ISSUE;
            last_grant_q    <= GRANT_READ;
            inst_q          <= '0;
            count_q         <= '0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            inst_q          <= inst_d;
            count_q         <= count_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
            err_q           <= err_d;
        end
    end

    assign inst          = inst_q;
    assign count         = count_q;
    assign full          = w_full;
    assign empty         = w_empty;
    assign busy          = (state_q != ISSUE);
    assign rd_data_valid = rd_data_valid_q;
    assign rd_data       = rd_data_q;
    assign err           = err_q;

endmodule : fifo_inst_driver
`default_nettype wire

// File: tb/tb_fifo_inst_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_inst_driver
// Description : Self-checking bench for fifo_inst_driver: a FIFO RAM model
//               answering the instruction port, a transaction-level reference
//               model compared every cycle, and directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_inst_driver;
    import fifo_drv_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int MOS   = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic          flush = 1'b0;
    logic [DW+1:0] inst;
    logic [DW-1:0] DO = '0;
    logic          read_valid = 1'b0;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;

    fifo_inst_driver #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MOS)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .flush         (flush),
        .inst          (inst),
        .DO            (DO),
        .read_valid    (read_valid),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // FIFO RAM model: reacts to the instruction word, returns read data
    // with read_valid one cycle after the RE instruction.
    // ------------------------------------------------------------------
    logic [DW-1:0] fm_q[$];
    logic          fm_pend = 1'b0;
    logic [DW-1:0] fm_pdata = '0;
    logic          inject = 1'b0;

    always @(posedge clk) begin
        #2;
        if (!rstn) begin
            fm_q.delete();
            fm_pend    = 1'b0;
            read_valid = inject;
            DO         = '0;
        end else begin
            read_valid = fm_pend | inject;
            DO         = fm_pend ? fm_pdata : 8'hEE;
            fm_pend    = 1'b0;
            if (inst[INST_WE]) begin
                chk("fifo_overflow", 32'(fm_q.size() < DEPTH), 1);
                fm_q.push_back(inst[DW-1:0]);
            end
            if (inst[INST_RE]) begin
                chk("fifo_underflow", 32'(fm_q.size() != 0), 1);
                if (fm_q.size() != 0) begin
                    fm_pend  = 1'b1;
                    fm_pdata = fm_q.pop_front();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: occupancy as an integer, in-flight reads as a queue
    // of drain flags, data integrity as a queue of written words.
    // ------------------------------------------------------------------
    logic [DW+1:0] m_inst;
    int            m_count;
    bit            m_tags[$];
    bit            m_last_w;
    int            m_mode;      // 0 normal, 1 draining, 2 waiting for returns
    bit            m_err;
    bit            m_rdv;
    logic [DW-1:0] m_rdd;
    logic [DW-1:0] sb_fifo[$];
    logic [DW-1:0] sb_resp[$];

    task automatic model_reset();
        m_inst   = '0;
        m_count  = 0;
        m_tags.delete();
        m_last_w = 1'b0;
        m_mode   = 0;
        m_err    = 1'b0;
        m_rdv    = 1'b0;
        m_rdd    = '0;
        sb_fifo.delete();
        sb_resp.delete();
    endtask

    always @(negedge clk) begin
        int            os;
        int            old_count;
        bit            wv, rv, e_wr, e_rd, drn, t;
        logic [DW-1:0] d;
        if (!rstn) begin
            chk("rst_inst", inst, 0);
            chk("rst_count", count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
            chk("rst_rdv", rd_data_valid, 0);
            model_reset();
        end else begin
            chk("inst", inst, m_inst);
            chk("we_re_excl", inst[INST_WE] & inst[INST_RE], 0);
            chk("count", count, m_count);
            chk("full", full, m_count == DEPTH);
            chk("empty", empty, m_count == 0);
            chk("busy", busy, m_mode != 0);
            chk("err", err, m_err);
            chk("rd_data_valid", rd_data_valid, m_rdv);
            if (m_rdv) begin
                chk("rd_data", rd_data, m_rdd);
                chk("resp_expected", 32'(sb_resp.size() != 0), 1);
                if (sb_resp.size() != 0) chk("rd_data_order", rd_data, sb_resp.pop_front());
            end

            os   = m_tags.size();
            wv   = (m_mode == 0) && wr_valid && (m_count < DEPTH);
            rv   = (m_mode == 0) && rd_req_valid && (m_count > 0) && (os < MOS);
            e_wr = wv && (!rv || !m_last_w);
            e_rd = rv && (!wv || m_last_w);
            chk("wr_ready", wr_ready, e_wr);
            chk("rd_req_ready", rd_req_ready, e_rd);

            drn       = (m_mode == 1) && (m_count > 0) && (os < MOS);
            old_count = m_count;
            if (e_wr) begin
                m_inst   = {2'b10, wr_data};
                m_count  = m_count + 1;
                m_last_w = 1'b1;
                sb_fifo.push_back(wr_data);
            end else if (e_rd || drn) begin
                m_inst  = {2'b01, m_inst[DW-1:0]};
                m_count = m_count - 1;
                if (e_rd) m_last_w = 1'b0;
                if (sb_fifo.size() != 0) begin
                    d = sb_fifo.pop_front();
                    if (e_rd) sb_resp.push_back(d);
                end
            end else begin
                m_inst = {2'b00, m_inst[DW-1:0]};
            end

            m_rdv = 1'b0;
            if (read_valid) begin
                if (os == 0) m_err = 1'b1;
                else begin
                    t = m_tags.pop_front();
                    if (!t) begin
                        m_rdv = 1'b1;
                        m_rdd = DO;
                    end
                end
            end
            if (e_rd || drn) m_tags.push_back(drn);

            case (m_mode)
                0: if (flush) m_mode = 1;
                1: if (old_count == 0) m_mode = 2;
                default: if (os == 0) m_mode = 0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid     = 1'b0;
        rd_req_valid = 1'b0;
        flush        = 1'b0;
        inject       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic wr_one(input logic [DW-1:0] v);
        bit got = 1'b0;
        wr_valid = 1'b1;
        wr_data  = v;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        chk("wr_accept", 32'(got), 1);
    endtask

    task automatic rd_one();
        bit got = 1'b0;
        rd_req_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = rd_req_ready;
            tick();
        end
        rd_req_valid = 1'b0;
        chk("rd_accept", 32'(got), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        string         gexp;
        byte           gch;
        int            re_n, rdv_n, acc, drain_re, busy_drop;
        int            re_k[$];
        int            rdv_k[$];
        logic [DW-1:0] rdv_d[$];

        // Reset state
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        chk("reset_inst", inst, 0);
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        chk("reset_rd_data", rd_data, 0);
        tick();
        rstn = 1'b1;

        // Two back-to-back writes
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(negedge clk);
        chk("wr_ready_first", wr_ready, 1);
        tick();
        wr_data = 8'h3C;
        @(negedge clk);
        chk("inst_A5", inst, 10'h2A5);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("inst_3C", inst, 10'h23C);
        chk("count_2", count, 2);
        tick();

        // Fill to full, ninth write is blocked
        do_reset();
        for (int v = 0; v < 8; v++) wr_one(8'(v));
        wr_valid = 1'b1;
        wr_data  = 8'h08;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_when_8", full, 1);
            chk("wr_ready_blocked", wr_ready, 0);
            tick();
        end
        wr_valid = 1'b0;
        chk("fifo_holds_8", 32'(fm_q.size()), 8);

        // Drain to 4 with reads, then contend for 6 cycles
        repeat (4) rd_one();
        repeat (3) tick();
        gexp = "WRWRWR";
        wr_valid     = 1'b1;
        rd_req_valid = 1'b1;
        wr_data      = 8'($urandom);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            gch = wr_ready ? 8'h57 : (rd_req_ready ? 8'h52 : 8'h2D);
            chk("grant_order", 32'(gch), 32'(gexp[k]));
            chk("count_4_or_5", 32'((count == 4) || (count == 5)), 1);
            tick();
            wr_data = 8'($urandom);
        end
        idle_inputs();
        repeat (4) tick();

        // Read latency: response two cycles after its RE instruction
        do_reset();
        wr_one(8'h11);
        wr_one(8'h22);
        rd_req_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (inst[INST_RE]) re_k.push_back(k);
            if (rd_data_valid) begin
                rdv_k.push_back(k);
                rdv_d.push_back(rd_data);
            end
            if (rd_req_valid && rd_req_ready) acc++;
            tick();
            if (acc == 2) rd_req_valid = 1'b0;
        end
        rd_req_valid = 1'b0;
        chk("lat_re_count", 32'(re_k.size()), 2);
        chk("lat_rdv_count", 32'(rdv_k.size()), 2);
        if (re_k.size() == 2 && rdv_k.size() == 2) begin
            chk("lat_first", 32'(rdv_k[0] - re_k[0]), 2);
            chk("lat_second", 32'(rdv_k[1] - re_k[1]), 2);
            chk("lat_data0", rdv_d[0], 8'h11);
            chk("lat_data1", rdv_d[1], 8'h22);
        end

        // Flush with one normal read issued in the same cycle
        do_reset();
        for (int v = 1; v <= 5; v++) wr_one(8'(8'h50 + v));
        rd_req_valid = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        chk("flush_rd_accept", rd_req_ready, 1);
        tick();
        rd_req_valid = 1'b0;
        flush        = 1'b0;
        re_n = 0; rdv_n = 0; busy_drop = 0;
        rdv_d.delete();
        for (int k = 0; k < 40 && !busy_drop; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_after_flush", busy, 1);
            if (inst[INST_RE]) re_n++;
            if (rd_data_valid) begin
                rdv_n++;
                rdv_d.push_back(rd_data);
            end
            if (!busy) busy_drop = 1;
            tick();
        end
        drain_re = re_n - 1;
        chk("flush_busy_released", 32'(busy_drop), 1);
        chk("flush_drain_re", 32'(drain_re), 4);
        chk("flush_rdv_count", 32'(rdv_n), 1);
        if (rdv_d.size() != 0) chk("flush_rdv_data", rdv_d[0], 8'h51);
        @(negedge clk);
        chk("flush_count_0", count, 0);
        tick();

        // Stray read_valid sets sticky err, no response
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("err_set", err, 1);
        chk("err_no_rdv", rd_data_valid, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", err, 1);
        tick();

        // Reset asserted in the middle of a drain
        for (int v = 0; v < 6; v++) wr_one(8'($urandom));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        chk("midrst_inst", inst, 0);
        chk("midrst_count", count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        repeat (2) tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_count", count, 0);
        chk("post_rst_busy", busy, 0);
        tick();

        // Random traffic against the reference model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            wr_valid     = ($urandom_range(0, 99) < 55);
            wr_data      = 8'($urandom);
            rd_req_valid = ($urandom_range(0, 99) < 50);
            flush        = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle_inputs();
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_inst_driver
`default_nettype wire
